// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes and M-extension op encoding shared by ALU, decoder and mul/div.
// ALU_MULDIV_SIGNED_EN widens md_op_t to 3 bits and adds MULH, MULHSU, DIV, REM.
package alu_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

`ifdef ALU_MULDIV_SIGNED_EN
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_t;

    function automatic logic md_is_div(input md_op_t op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic md_pick_hi(input md_op_t op);
        return op inside {MD_MULH, MD_MULHSU, MD_MULHU, MD_REM, MD_REMU};
    endfunction

    function automatic logic md_sgn_a(input md_op_t op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic md_sgn_b(input md_op_t op);
        return op inside {MD_MULH, MD_DIV, MD_REM};
    endfunction
`else
    typedef enum logic [1:0] {
        MD_MUL   = 2'd0,
        MD_MULHU = 2'd1,
        MD_DIVU  = 2'd2,
        MD_REMU  = 2'd3
    } md_op_t;

    function automatic logic md_is_div(input md_op_t op);
        return (op == MD_DIVU) || (op == MD_REMU);
    endfunction

    function automatic logic md_pick_hi(input md_op_t op);
        return (op == MD_MULHU) || (op == MD_REMU);
    endfunction
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_NEG,
        ST_DONE
    } md_state_t;

    // Carry out of bit 31, recovered from the operand MSBs and the sum MSB.
    function automatic logic add_cout(input logic a31, input logic b31, input logic s31);
        return (a31 & b31) | ((a31 | b31) & ~s31);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: 32-step shift-add multiply / restoring divide on the shared ALU (ADD/SUB).
// ALU_MULDIV_SIGNED_EN adds signed ops with a sign-fix cycle before DONE.
module alu_muldiv_seq
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  md_op_t          in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            alu_own,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data
);

    md_state_t        r_state;
    md_state_t        w_nxt;
    md_op_t           r_op;
    logic [XLEN-1:0]  r_a;
    logic [XLEN-1:0]  r_b;
    logic [XLEN-1:0]  r_d;
    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_out;
    logic [CNT_W-1:0] r_cnt;

    logic             w_div;
    logic             w_accept;
    logic             w_dz;
    logic             w_last;
    logic             w_cy;
    logic             w_nb;
    logic [XLEN-1:0]  w_rp;
    logic [XLEN-1:0]  w_hi_nx;
    logic [XLEN-1:0]  w_lo_nx;
    logic [XLEN-1:0]  w_res;
    logic [XLEN-1:0]  w_ua;
    logic [XLEN-1:0]  w_ub;

    assign w_div    = md_is_div(r_op);
    assign w_accept = in_valid & (r_state == ST_IDLE) & ~flush;
    assign w_dz     = w_div & (r_b == '0);
    assign w_last   = &r_cnt;
    assign w_rp     = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
    assign out_data = r_out;

`ifdef ALU_MULDIV_SIGNED_EN
    logic                r_neg;
    logic                w_na;
    logic                w_nbs;
    logic [2*XLEN-1:0]   w_p;
    logic [2*XLEN-1:0]   w_pn;

    assign w_na  = md_sgn_a(r_op) & r_a[XLEN-1];
    assign w_nbs = md_sgn_b(r_op) & r_b[XLEN-1];
    assign w_ua  = w_na ? -r_a : r_a;
    assign w_ub  = w_nbs ? -r_b : r_b;
    assign w_p   = {r_hi, r_lo};
    assign w_pn  = r_neg ? -w_p : w_p;

    // Remainder sign is fixed on its own; quotient/product via 64-bit negate.
    always_comb begin
        if (w_div && md_pick_hi(r_op))
            w_res = r_neg ? -r_hi : r_hi;
        else if (md_pick_hi(r_op))
            w_res = w_pn[2*XLEN-1:XLEN];
        else
            w_res = w_pn[XLEN-1:0];
    end
`else
    assign w_ua  = r_a;
    assign w_ub  = r_b;
    assign w_res = md_pick_hi(r_op) ? w_hi_nx : w_lo_nx;
`endif

    assign w_cy = add_cout(alu_a[XLEN-1],
                           w_div ? ~alu_b[XLEN-1] : alu_b[XLEN-1],
                           alu_result[XLEN-1]);
    assign w_nb = r_hi[XLEN-1] | w_cy;

    always_comb begin
        if (w_div) begin
            w_hi_nx = w_nb ? alu_result : w_rp;
            w_lo_nx = {r_lo[XLEN-2:0], w_nb};
        end else if (r_lo[0]) begin
            w_hi_nx = {w_cy, alu_result[XLEN-1:1]};
            w_lo_nx = {alu_result[0], r_lo[XLEN-1:1]};
        end else begin
            w_hi_nx = {1'b0, r_hi[XLEN-1:1]};
            w_lo_nx = {r_hi[0], r_lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept) w_nxt = ST_LOAD;
            ST_LOAD: w_nxt = w_dz ? ST_DONE : ST_RUN;
`ifdef ALU_MULDIV_SIGNED_EN
            ST_RUN:  if (w_last) w_nxt = ST_NEG;
`else
            ST_RUN:  if (w_last) w_nxt = ST_DONE;
`endif
            ST_NEG:  w_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_nxt = ST_IDLE;
            default: w_nxt = ST_IDLE;
        endcase
        if (flush)
            w_nxt = ST_IDLE;
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_own   = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_ctrl  = ALU_ADD;
        unique case (r_state)
            ST_IDLE: in_ready = 1'b1;
            ST_RUN: begin
                alu_own  = 1'b1;
                alu_a    = w_div ? w_rp : r_hi;
                alu_b    = r_d;
                alu_ctrl = w_div ? ALU_SUB : ALU_ADD;
            end
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= MD_MUL;
            r_a   <= '0;
            r_b   <= '0;
            r_d   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_out <= '0;
            r_cnt <= '0;
`ifdef ALU_MULDIV_SIGNED_EN
            r_neg <= 1'b0;
`endif
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op <= in_op;
                        r_a  <= in_a;
                        r_b  <= in_b;
                    end
                end
                ST_LOAD: begin
                    r_cnt <= '0;
                    r_hi  <= '0;
                    r_lo  <= w_div ? w_ua : w_ub;
                    r_d   <= w_div ? w_ub : w_ua;
`ifdef ALU_MULDIV_SIGNED_EN
                    r_neg <= (w_div && md_pick_hi(r_op)) ? w_na : (w_na ^ w_nbs);
`endif
                    if (w_dz)
                        r_out <= md_pick_hi(r_op) ? r_a : '1;
                end
                ST_RUN: begin
                    r_hi  <= w_hi_nx;
                    r_lo  <= w_lo_nx;
                    r_cnt <= r_cnt + 1'b1;
`ifndef ALU_MULDIV_SIGNED_EN
                    if (w_last)
                        r_out <= w_res;
`endif
                end
`ifdef ALU_MULDIV_SIGNED_EN
                ST_NEG: r_out <= w_res;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: directed + random ops checked each cycle against a behavioural model.
// Bench provides the shared ALU; ALU_MULDIV_SIGNED_EN enables signed vectors.
module tb_alu_muldiv_seq;
    import alu_pkg::*;

`ifdef ALU_MULDIV_SIGNED_EN
    localparam int LAT  = 35;
    localparam int NOPS = 8;
`else
    localparam int LAT  = 34;
    localparam int NOPS = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    md_op_t      in_op = MD_MUL;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_ready;
    logic        alu_own;
    logic        out_valid;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic [31:0] out_data;
    logic [2:0]  alu_ctrl;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign alu_result = (alu_ctrl == ALU_SUB) ? alu_a - alu_b : alu_a + alu_b;

    alu_muldiv_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_own    (alu_own),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_div_op(input md_op_t op);
`ifdef ALU_MULDIV_SIGNED_EN
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
`else
        return op inside {MD_DIVU, MD_REMU};
`endif
    endfunction

    function automatic logic [31:0] ref_res(input md_op_t op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] p;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sp;
        p  = {32'b0, a} * {32'b0, b};
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        sp = '0;
        case (op)
            MD_MUL:   return p[31:0];
            MD_MULHU: return p[63:32];
            MD_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MD_REMU:  return (b == 0) ? a : a % b;
`ifdef ALU_MULDIV_SIGNED_EN
            MD_MULH: begin
                sp = sa * sb;
                return sp[63:32];
            end
            MD_MULHSU: begin
                sp = sa * $signed({32'b0, b});
                return sp[63:32];
            end
            MD_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                sp = sa / sb;
                return sp[31:0];
            end
            MD_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                sp = sa % sb;
                return sp[31:0];
            end
`endif
            default: return 32'h0;
        endcase
    endfunction

    // Model: cycles since acceptance (1 = first cycle after accept edge).
    bit          m_busy = 1'b0;
    bit          m_div = 1'b0;
    int          m_n = 0;
    int          m_lat = 0;
    logic [31:0] m_exp = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_n    <= 0;
        end else if (!m_busy) begin
            if (in_valid && !flush) begin
                m_busy <= 1'b1;
                m_n    <= 1;
                m_exp  <= ref_res(in_op, in_a, in_b);
                m_div  <= is_div_op(in_op);
                m_lat  <= (is_div_op(in_op) && in_b == 0) ? 2 : LAT;
            end
        end else if (flush) begin
            m_busy <= 1'b0;
        end else if (m_n >= m_lat && out_ready) begin
            m_busy <= 1'b0;
        end else begin
            m_n <= m_n + 1;
        end
    end

    bit e_own;
    bit e_val;

    always @(negedge clk) begin
        if (rst_n) begin
            e_own = m_busy && m_n >= 2 && m_n <= 33 && m_lat != 2;
            e_val = m_busy && m_n >= m_lat;
            chk("in_ready", 32'(in_ready), 32'(!m_busy));
            chk("alu_own", 32'(alu_own), 32'(e_own));
            chk("out_valid", 32'(out_valid), 32'(e_val));
            if (e_val)
                chk("out_data", out_data, m_exp);
            if (e_own) begin
                chk("alu_ctrl_run", 32'(alu_ctrl), 32'(m_div ? ALU_SUB : ALU_ADD));
            end else begin
                chk("alu_a_idle", alu_a, 32'h0);
                chk("alu_b_idle", alu_b, 32'h0);
                chk("alu_ctrl_idle", 32'(alu_ctrl), 32'(ALU_ADD));
            end
        end
    end

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_alu_own"}, 32'(alu_own), 32'd0);
        chk({tag, "_out_data"}, out_data, 32'h0);
        chk({tag, "_alu_a"}, alu_a, 32'h0);
        chk({tag, "_alu_b"}, alu_b, 32'h0);
        chk({tag, "_alu_ctrl"}, 32'(alu_ctrl), 32'(ALU_ADD));
    endtask

    task automatic issue(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [31:0] lit, input bit use_lit,
                         input int hold);
        int n;
        bit seen;
        out_ready = (hold == 0);
        issue(op, a, b);
        n = 0;
        seen = 1'b0;
        while (n < 60 && !seen) begin
            @(negedge clk);
            n++;
            if (out_valid) seen = 1'b1;
        end
        chk("latency", 32'(n), 32'(exp_lat));
        if (use_lit)
            chk("result_lit", out_data, lit);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", out_data, ref_res(op, a, b));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("back_idle", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        md_op_t      rop;
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        do_op(MD_MUL,   32'd7,         32'd6,         LAT, 32'd42,        1'b1, 0);
        do_op(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT, 32'hFFFF_FFFE, 1'b1, 0);
        do_op(MD_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT, 32'h0000_0001, 1'b1, 0);
        do_op(MD_DIVU,  32'd100,       32'd7,         LAT, 32'd14,        1'b1, 0);
        do_op(MD_REMU,  32'd100,       32'd7,         LAT, 32'd2,         1'b1, 0);
        do_op(MD_DIVU,  32'd5,         32'd0,         2,   32'hFFFF_FFFF, 1'b1, 0);
        do_op(MD_REMU,  32'd5,         32'd0,         2,   32'd5,         1'b1, 0);

        issue(MD_DIVU, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_idle", 32'(in_ready), 32'd1);
        repeat (40) @(posedge clk);
        #1;
        do_op(MD_MUL, 32'd3, 32'd3, LAT, 32'd9, 1'b1, 0);

        @(posedge clk); #1;
        in_valid = 1'b1;
        flush    = 1'b1;
        in_op    = MD_MUL;
        in_a     = 32'd2;
        in_b     = 32'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_wins", 32'(in_ready), 32'd1);

        do_op(MD_DIVU, 32'd1000, 32'd10, LAT, 32'd100, 1'b1, 5);

        issue(MD_MUL, 32'd123, 32'd456);
        repeat (15) @(posedge clk);
        #1;
        chk("own_before_rst", 32'(alu_own), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        do_op(MD_MUL, 32'd123, 32'd456, LAT, 32'd56088, 1'b1, 0);

`ifdef ALU_MULDIV_SIGNED_EN
        do_op(MD_DIV, -32'sd7, 32'd2, LAT, -32'sd3, 1'b1, 0);
        do_op(MD_REM, -32'sd7, 32'd2, LAT, -32'sd1, 1'b1, 0);
        do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, LAT, 32'h8000_0000, 1'b1, 0);
        do_op(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, LAT, 32'h0, 1'b1, 0);
        do_op(MD_DIV, -32'sd5, 32'd0, 2, 32'hFFFF_FFFF, 1'b1, 0);
        do_op(MD_REM, -32'sd5, 32'd0, 2, -32'sd5, 1'b1, 0);
        do_op(MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT, 32'h0, 1'b1, 0);
`endif

        for (int i = 0; i < 60; i++) begin
            rop = md_op_t'($urandom_range(0, NOPS - 1));
            ra  = $urandom;
            if ($urandom_range(0, 7) == 0)
                rb = 32'h0;
            else if ($urandom_range(0, 1) == 1)
                rb = $urandom;
            else
                rb = $urandom_range(1, 300);
            do_op(rop, ra, rb, (is_div_op(rop) && rb == 0) ? 2 : LAT, 32'h0, 1'b0,
                  $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
